// File: rtl/move_x_sequencer_if.sv
// Bundles the button, tick and counter feedback signals of the X-move sequencer,
// together with the strobes it drives into the X-coordinate counter chain.
// The slave modport is the sequencer. The master modport is whatever drives it.
interface move_x_sequencer_if;
    logic        frame_tick;
    logic        start;
    logic        btn_r;
    logic        btn_l;
    logic        freeze;
    logic [15:0] xcoord;
    logic        up;
    logic        dw;
    logic        ld;
    logic [15:0] ld_val;
    logic        at_right;
    logic        at_left;
    logic        busy;

    modport master (
        output frame_tick, start, btn_r, btn_l, freeze, xcoord,
        input  up, dw, ld, ld_val, at_right, at_left, busy
    );

    modport slave (
        input  frame_tick, start, btn_r, btn_l, freeze, xcoord,
        output up, dw, ld, ld_val, at_right, at_left, busy
    );
endinterface

// File: rtl/move_x_sequencer.sv
// Horizontal move sequencer for the Wild Cube player object.
// It turns button requests, the start command and the frame tick into one-cycle
// up/dw/ld strobes for the 16-bit X counter. It reads the counter back so that
// motion stops at the playfield edges.
// Optional macro MOVE_WRAP_EN: at an edge the object wraps to the opposite side
// (a load strobe) instead of stopping.
module move_x_sequencer #(
    parameter logic [15:0] X_MIN   = 16'd0,
    parameter logic [15:0] X_MAX   = 16'd605,
    parameter logic [15:0] X_START = 16'd300,
    parameter logic [3:0]  STEPS   = 4'd2
) (
    input  logic              clk,
    input  logic              reset,
    move_x_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        STEP_R,
        STEP_L,
        GAP
    } state_t;

    state_t      state, state_next;
    logic [3:0]  step_cnt, step_cnt_next;
    logic        dir_r, dir_r_next;
    logic        start_q;
    logic        start_pend, start_pend_next;
    logic        start_rise;
    logic        up_q, dw_q, ld_q;
    logic        up_next, dw_next, ld_next;
    logic [15:0] ld_val_q, ld_val_next;
    logic        at_right_q, at_left_q;

    assign start_rise = bus.start & ~start_q;

    // Next-state and strobe decode. A strobe is registered on the transition, so it is
    // high in the cycle that follows the decision. The STEP/GAP alternation keeps an
    // idle cycle between strobes, which gives the counter feedback time to settle.
    always_comb begin
        state_next      = state;
        step_cnt_next   = step_cnt;
        dir_r_next      = dir_r;
        start_pend_next = start_pend | start_rise;
        up_next         = 1'b0;
        dw_next         = 1'b0;
        ld_next         = 1'b0;
        ld_val_next     = ld_val_q;
        case (state)
            IDLE: begin
                if (start_pend_next) begin
                    state_next      = LOAD;
                    ld_next         = 1'b1;
                    ld_val_next     = X_START;
                    start_pend_next = 1'b0;
                end else if (bus.frame_tick && !bus.freeze && (bus.btn_r ^ bus.btn_l)) begin
                    state_next    = bus.btn_r ? STEP_R : STEP_L;
                    dir_r_next    = bus.btn_r;
                    step_cnt_next = STEPS;
                end
            end
            LOAD: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                state_next = IDLE;
            end
            STEP_R: begin
                if (bus.freeze || !bus.btn_r) begin
                    state_next = IDLE;
                end else if (bus.xcoord >= X_MAX) begin
`ifdef MOVE_WRAP_EN
                    state_next  = SETTLE;
                    ld_next     = 1'b1;
                    ld_val_next = X_MIN;
`else
                    state_next = IDLE;
`endif
                end else begin
                    up_next       = 1'b1;
                    step_cnt_next = step_cnt - 4'd1;
                    state_next    = GAP;
                end
            end
            STEP_L: begin
                if (bus.freeze || !bus.btn_l) begin
                    state_next = IDLE;
                end else if (bus.xcoord <= X_MIN) begin
`ifdef MOVE_WRAP_EN
                    state_next  = SETTLE;
                    ld_next     = 1'b1;
                    ld_val_next = X_MAX;
`else
                    state_next = IDLE;
`endif
                end else begin
                    dw_next       = 1'b1;
                    step_cnt_next = step_cnt - 4'd1;
                    state_next    = GAP;
                end
            end
            GAP: begin
                if (step_cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    state_next = dir_r ? STEP_R : STEP_L;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, strobe and edge-flag registers. Reset aborts a burst at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            step_cnt   <= 4'd0;
            dir_r      <= 1'b0;
            start_q    <= 1'b0;
            start_pend <= 1'b0;
            up_q       <= 1'b0;
            dw_q       <= 1'b0;
            ld_q       <= 1'b0;
            ld_val_q   <= X_START;
        end else begin
            state      <= state_next;
            step_cnt   <= step_cnt_next;
            dir_r      <= dir_r_next;
            start_q    <= bus.start;
            start_pend <= start_pend_next;
            up_q       <= up_next;
            dw_q       <= dw_next;
            ld_q       <= ld_next;
            ld_val_q   <= ld_val_next;
        end
    end

    // Edge flags follow the counter feedback with one cycle of latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            at_right_q <= 1'b0;
            at_left_q  <= 1'b0;
        end else begin
            at_right_q <= (bus.xcoord == X_MAX);
            at_left_q  <= (bus.xcoord == X_MIN);
        end
    end

    assign bus.up       = up_q;
    assign bus.dw       = dw_q;
    assign bus.ld       = ld_q;
    assign bus.ld_val   = ld_val_q;
    assign bus.at_right = at_right_q;
    assign bus.at_left  = at_left_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_move_x_sequencer.sv
// Testbench for move_x_sequencer. A simple X counter model closes the feedback loop.
// Each movement request is predicted from the movement rules: step count, edge stop
// or wrap, busy length and final coordinate.
module tb_move_x_sequencer;

    localparam int X_MIN_I   = 0;
    localparam int X_MAX_I   = 605;
    localparam int X_START_I = 300;
    localparam int STEPS_I   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    move_x_sequencer_if bus ();

    move_x_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    logic [15:0] x_reg = 16'd0;
    logic        preset_req = 1'b0;
    logic [15:0] preset_val = 16'd0;
    int          up_count = 0;
    int          dw_count = 0;
    int          ld_count = 0;
    int          busy_count = 0;
    int          last_ld_val = -1;
    bit          strobe_prev = 1'b0;
    int          errors = 0;
    int          checks = 0;

    assign bus.xcoord = x_reg;

    // Counter chain model plus a preset path so the bench can place the object.
    always @(posedge clk) begin
        if (preset_req) x_reg <= preset_val;
        else if (bus.ld) x_reg <= bus.ld_val;
        else if (bus.up) x_reg <= x_reg + 16'd1;
        else if (bus.dw) x_reg <= x_reg - 16'd1;
    end

    // Strobe tallies as the counter sees them at the clock edge.
    always @(posedge clk) begin
        if (bus.up) up_count <= up_count + 1;
        if (bus.dw) dw_count <= dw_count + 1;
        if (bus.ld) begin
            ld_count    <= ld_count + 1;
            last_ld_val <= int'(bus.ld_val);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Mid-cycle watch on the strobes: only one strobe at a time, and none in the preceding cycle.
    always @(negedge clk) begin
        if (!reset) begin
            strobe_prev = 1'b0;
        end else begin
            if (bus.up || bus.dw || bus.ld) begin
                checkOutput("strobe_onehot", int'(bus.up) + int'(bus.dw) + int'(bus.ld), 1);
                checkOutput("strobe_gap", int'(strobe_prev), 0);
            end
            strobe_prev = bus.up | bus.dw | bus.ld;
            if (bus.busy) busy_count++;
        end
    end

    // Reference: walk the burst step by step on plain integers.
    function automatic void predict_burst(input bit r, input bit l, input bit frz, input int x0,
                                          output int ups, output int dws, output int lds,
                                          output int busyc, output int xf);
        ups = 0; dws = 0; lds = 0; busyc = 0; xf = x0;
        if (frz || (r == l)) return;
        for (int k = 0; k < STEPS_I; k++) begin
            busyc++;
            if (r ? (xf >= X_MAX_I) : (xf <= X_MIN_I)) begin
`ifdef MOVE_WRAP_EN
                lds++;
                busyc++;
                xf = r ? X_MIN_I : X_MAX_I;
`endif
                break;
            end
            if (r) begin ups++; xf++; end
            else begin dws++; xf--; end
            busyc++;
        end
    endfunction

    task automatic setX(input int v);
        preset_val = 16'(v);
        preset_req = 1'b1;
        @(negedge clk);
        preset_req = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input bit r, input bit l, input bit frz,
                                 input int x0, input bit mid_events);
        int u0, d0, l0, b0;
        int e_up, e_dw, e_ld, e_busy, e_x;
        setX(x0);
        bus.btn_r  = r;
        bus.btn_l  = l;
        bus.freeze = frz;
        u0 = up_count; d0 = dw_count; l0 = ld_count; b0 = busy_count;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        if (mid_events) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            bus.frame_tick = 1'b1;
            @(negedge clk);
            bus.frame_tick = 1'b0;
        end
        repeat (12) @(negedge clk);
        predict_burst(r, l, frz, x0, e_up, e_dw, e_ld, e_busy, e_x);
        if (mid_events) begin
            e_ld   += 1;
            e_busy += 2;
            e_x     = X_START_I;
        end
        checkOutput({name, ".up"},   up_count - u0,   e_up);
        checkOutput({name, ".dw"},   dw_count - d0,   e_dw);
        checkOutput({name, ".ld"},   ld_count - l0,   e_ld);
        checkOutput({name, ".busy"}, busy_count - b0, e_busy);
        checkOutput({name, ".x"},    int'(x_reg),     e_x);
        bus.btn_r  = 1'b0;
        bus.btn_l  = 1'b0;
        bus.freeze = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int u0, l0, b0, sel, x0;
        bit r, l, frz;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.btn_r      = 1'b0;
        bus.btn_l      = 1'b0;
        bus.freeze     = 1'b0;

        // Asynchronous reset, checked before any clock edge acts on it.
        #2 reset = 1'b0;
        #1;
        checkOutput("rst.up",       int'(bus.up),       0);
        checkOutput("rst.dw",       int'(bus.dw),       0);
        checkOutput("rst.ld",       int'(bus.ld),       0);
        checkOutput("rst.busy",     int'(bus.busy),     0);
        checkOutput("rst.ld_val",   int'(bus.ld_val),   X_START_I);
        checkOutput("rst.at_right", int'(bus.at_right), 0);
        checkOutput("rst.at_left",  int'(bus.at_left),  0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Start pulse: a single load of the start coordinate, busy for two cycles.
        u0 = up_count; l0 = ld_count; b0 = busy_count;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("start.ld",     ld_count - l0,   1);
        checkOutput("start.up",     up_count - u0,   0);
        checkOutput("start.busy",   busy_count - b0, 2);
        checkOutput("start.ld_val", last_ld_val,     X_START_I);
        checkOutput("start.x",      int'(x_reg),     X_START_I);

        // Directed movement cases, including both edges and suppressed requests.
        applyStimulus("right300", 1, 0, 0, 300, 0);
        applyStimulus("right604", 1, 0, 0, 604, 0);
        checkOutput("right604.at_right", int'(bus.at_right), 1);
        applyStimulus("left0", 0, 1, 0, 0, 0);
        checkOutput("left0.at_left", int'(bus.at_left), (x_reg == 16'd0) ? 1 : 0);
        applyStimulus("left1", 0, 1, 0, 1, 0);
        applyStimulus("both", 1, 1, 0, 300, 0);
        applyStimulus("freeze", 0, 1, 1, 300, 0);
        applyStimulus("none", 0, 0, 0, 300, 0);
        applyStimulus("pending", 1, 0, 0, 300, 1);

        // The edge flags lag the coordinate by exactly one cycle.
        setX(600);
        setX(605);
        checkOutput("lat.at_right_early", int'(bus.at_right), 0);
        @(negedge clk);
        checkOutput("lat.at_right", int'(bus.at_right), 1);
        setX(1);
        setX(0);
        checkOutput("lat.at_left_early", int'(bus.at_left), 0);
        @(negedge clk);
        checkOutput("lat.at_left", int'(bus.at_left), 1);

        // Reset during the first up strobe aborts the burst.
        setX(300);
        u0 = up_count;
        bus.btn_r = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        for (int i = 0; i < 10 && !bus.up; i++) @(negedge clk);
        checkOutput("rstmid.wait_up", int'(bus.up), 1);
        reset = 1'b0;
        #1;
        checkOutput("rstmid.up",   int'(bus.up),   0);
        checkOutput("rstmid.busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rstmid.ups", up_count - u0, 0);
        checkOutput("rstmid.x",   int'(x_reg),   300);
        bus.btn_r = 1'b0;
        repeat (2) @(negedge clk);

        // Random requests, biased toward the playfield edges.
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) x0 = int'($urandom_range(0, 2));
            else if (sel == 1) x0 = int'($urandom_range(603, 605));
            else x0 = int'($urandom_range(0, 605));
            r   = 1'($urandom_range(0, 1));
            l   = 1'($urandom_range(0, 1));
            frz = ($urandom_range(0, 3) == 0);
            applyStimulus($sformatf("rnd%0d", n), r, l, frz, x0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
